// File: rtl/word_guess_entry.sv
// word_guess_entry: keystroke entry for the word-guess game.
// Builds the secret word, then stages and presents single-letter guesses.
module word_guess_entry #(
   parameter int LETTERS     = 5,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 clk,
   input  logic                 nRst,
   input  logic                 key_valid,
   input  logic [7:0]           key_data,
   input  logic                 key_del,
   input  logic                 key_submit,
   input  logic                 game_rdy,
   input  logic                 red_busy,
   input  logic                 gameEnd,
   output logic [8*LETTERS-1:0] setWord,
   output logic                 toggle_state,
   output logic [7:0]           guess,
   output logic [2:0]           entry_count,
   output logic                 staged,
   output logic                 word_locked,
   output logic                 guess_busy,
   output logic                 err
);

   localparam int          WW   = 8*LETTERS;
   localparam int          TW   = $clog2(TIMEOUT_CYC+1);
   localparam logic [2:0]  FULL = 3'(LETTERS);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC-1);

   typedef enum logic [2:0] {
      W_ENTRY, W_CONFIRM, G_IDLE,
      G_GAP, G_SEND, G_WAIT
   } state_t;

   state_t        state;
   logic [7:0]    stg;
   logic [TW-1:0] tmo;

   logic       is_up, is_lo, ok;
   logic [7:0] letter;
   logic       do_del, do_sub, do_key;

   always_comb begin
      is_up  = (key_data >= 8'h41) && (key_data <= 8'h5A);
      is_lo  = (key_data >= 8'h61) && (key_data <= 8'h7A);
      ok     = is_up || is_lo;
      letter = is_lo ? key_data - 8'h20 : key_data;
      do_del = key_del;
      do_sub = !key_del && key_submit;
      do_key = !key_del && !key_submit && key_valid;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state        <= W_ENTRY;
         setWord      <= '0;
         guess        <= '0;
         entry_count  <= '0;
         toggle_state <= 1'b0;
         staged       <= 1'b0;
         word_locked  <= 1'b0;
         guess_busy   <= 1'b0;
         err          <= 1'b0;
         stg          <= '0;
         tmo          <= '0;
      end else if (gameEnd) begin
         state        <= W_ENTRY;
         setWord      <= '0;
         guess        <= '0;
         entry_count  <= '0;
         toggle_state <= 1'b0;
         staged       <= 1'b0;
         word_locked  <= 1'b0;
         guess_busy   <= 1'b0;
         err          <= 1'b0;
         stg          <= '0;
         tmo          <= '0;
      end else begin
         toggle_state <= 1'b0;
         err          <= 1'b0;
         unique case (state)
            W_ENTRY: begin
               unique case (1'b1)
                  do_del: begin
                     if (entry_count != 3'd0) begin
                        setWord     <= setWord >> 8;
                        entry_count <= entry_count - 3'd1;
                     end
                  end
                  do_sub: begin
                     if (entry_count == FULL)
                        state <= W_CONFIRM;
                     else
                        err <= 1'b1;
                  end
                  do_key: begin
                     if (!ok || entry_count == FULL) begin
                        err <= 1'b1;
                     end else begin
                        setWord     <= {setWord[WW-9:0], letter};
                        entry_count <= entry_count + 3'd1;
                     end
                  end
                  default: ;
               endcase
            end
            W_CONFIRM: begin
               if (game_rdy) begin
                  toggle_state <= 1'b1;
                  word_locked  <= 1'b1;
                  state        <= G_IDLE;
               end
            end
            G_IDLE: begin
               unique case (1'b1)
                  do_del: staged <= 1'b0;
                  do_sub: begin
                     if (staged && game_rdy) begin
                        guess      <= 8'h00;
                        guess_busy <= 1'b1;
                        staged     <= 1'b0;
                        state      <= G_GAP;
                     end else begin
                        err <= 1'b1;
                     end
                  end
                  do_key: begin
                     if (ok) begin
                        stg    <= letter;
                        staged <= 1'b1;
                     end else begin
                        err <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            // zero cycle forces a bus edge even for a repeated letter
            G_GAP: begin
               guess <= stg;
               tmo   <= '0;
               state <= G_SEND;
            end
            G_SEND: begin
               if (red_busy) begin
                  state <= G_WAIT;
               end else if (tmo == TMAX) begin
                  err        <= 1'b1;
                  guess_busy <= 1'b0;
                  state      <= G_IDLE;
               end else begin
                  tmo <= tmo + TW'(1);
               end
            end
            G_WAIT: begin
               if (game_rdy) begin
                  guess_busy <= 1'b0;
                  state      <= G_IDLE;
               end
            end
            default: state <= W_ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_word_guess_entry.sv
// tb_word_guess_entry: scoreboard bench for word_guess_entry.
// Expectations are queued with a due cycle and checked on the falling edge.
module tb_word_guess_entry;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        key_valid = 1'b0;
   logic [7:0]  key_data = 8'h00;
   logic        key_del = 1'b0;
   logic        key_submit = 1'b0;
   logic        game_rdy = 1'b0;
   logic        red_busy = 1'b0;
   logic        gameEnd = 1'b0;
   logic [39:0] setWord;
   logic        toggle_state;
   logic [7:0]  guess;
   logic [2:0]  entry_count;
   logic        staged;
   logic        word_locked;
   logic        guess_busy;
   logic        err;

   word_guess_entry #(.LETTERS(5), .TIMEOUT_CYC(64)) dut (
      .clk(clk), .nRst(nRst),
      .key_valid(key_valid), .key_data(key_data),
      .key_del(key_del), .key_submit(key_submit),
      .game_rdy(game_rdy), .red_busy(red_busy),
      .gameEnd(gameEnd), .setWord(setWord),
      .toggle_state(toggle_state), .guess(guess),
      .entry_count(entry_count), .staged(staged),
      .word_locked(word_locked), .guess_busy(guess_busy),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef enum {
      F_WORD, F_GUESS, F_CNT, F_TOG,
      F_STG, F_LCK, F_BSY, F_ERR
   } fld_e;

   typedef struct {
      int          due;
      fld_e        f;
      logic [39:0] v;
   } sb_t;

   sb_t sb[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  mi;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [39:0] o,
                      input logic [39:0] e);
      n_cmp++;
      if (o !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, o, e);
      end
   endtask

   function automatic logic [39:0] obs(input fld_e f);
      case (f)
         F_WORD:  return setWord;
         F_GUESS: return 40'(guess);
         F_CNT:   return 40'(entry_count);
         F_TOG:   return 40'(toggle_state);
         F_STG:   return 40'(staged);
         F_LCK:   return 40'(word_locked);
         F_BSY:   return 40'(guess_busy);
         default: return 40'(err);
      endcase
   endfunction

   always @(negedge clk) begin
      mi = 0;
      while (mi < sb.size()) begin
         if (sb[mi].due == cyc) begin
            chk($sformatf("%s@%0d", sb[mi].f.name(), cyc),
                obs(sb[mi].f), sb[mi].v);
            sb.delete(mi);
         end else begin
            mi++;
         end
      end
   end

   task automatic push(input fld_e f, input logic [39:0] v,
                       input int d);
      sb_t s;
      s.due = cyc + d;
      s.f   = f;
      s.v   = v;
      sb.push_back(s);
   endtask

   task automatic all_zero(input int d);
      push(F_WORD, 0, d);  push(F_GUESS, 0, d);
      push(F_CNT, 0, d);   push(F_TOG, 0, d);
      push(F_STG, 0, d);   push(F_LCK, 0, d);
      push(F_BSY, 0, d);   push(F_ERR, 0, d);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic press(input logic [7:0] c);
      key_valid = 1'b1;
      key_data  = c;
      tick();
      key_valid = 1'b0;
      key_data  = 8'h00;
   endtask

   task automatic del_k();
      key_del = 1'b1;
      tick();
      key_del = 1'b0;
   endtask

   task automatic sub_k();
      key_submit = 1'b1;
      tick();
      key_submit = 1'b0;
   endtask

   task automatic hold_4c();
      push(F_GUESS, 40'h4C, 1);
      push(F_BSY, 1, 1);
      tick();
   endtask

   // full guess handshake: stage, submit, gap, send, wait, idle
   task automatic send_guess(input logic [7:0] c,
                             input logic [7:0] up);
      push(F_STG, 1, 1);
      press(c);
      push(F_GUESS, 0, 1);
      push(F_BSY, 1, 1);
      push(F_STG, 0, 1);
      sub_k();
      game_rdy = 1'b0;
      push(F_GUESS, 40'(up), 1);
      tick();
      red_busy = 1'b1;
      push(F_GUESS, 40'(up), 1);
      push(F_BSY, 1, 1);
      tick();
      red_busy = 1'b0;
      game_rdy = 1'b1;
      push(F_GUESS, 40'(up), 1);
      push(F_BSY, 0, 1);
      tick();
   endtask

   logic [39:0] w_hello [5] = '{
      40'h48, 40'h4845, 40'h48454C,
      40'h48454C4C, 40'h48454C4C4F
   };
   logic [7:0] k_hello [5] = '{"h", "e", "l", "l", "o"};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      all_zero(0);
      nRst = 1'b1;
      tick();

      // hello, overflow letter, confirm
      game_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(F_WORD, w_hello[i], 1);
         push(F_CNT, 40'(i + 1), 1);
         press(k_hello[i]);
      end
      push(F_ERR, 1, 1);
      push(F_WORD, 40'h48454C4C4F, 1);
      push(F_CNT, 5, 1);
      press("x");
      push(F_ERR, 0, 1);
      push(F_TOG, 0, 1);
      push(F_TOG, 1, 2);
      push(F_LCK, 1, 2);
      push(F_CNT, 5, 2);
      push(F_TOG, 0, 3);
      sub_k();
      tick();
      tick();
      push(F_WORD, 40'h48454C4C4F, 1);
      push(F_STG, 1, 1);
      press("a");

      gameEnd = 1'b1;
      all_zero(1);
      tick();
      gameEnd = 1'b0;

      // delete, short submit, priority
      push(F_CNT, 0, 1);
      push(F_ERR, 0, 1);
      del_k();
      press("A");
      press("B");
      push(F_WORD, 40'h414243, 1);
      press("C");
      push(F_WORD, 40'h4142, 1);
      push(F_CNT, 2, 1);
      del_k();
      push(F_ERR, 1, 1);
      push(F_TOG, 0, 1);
      push(F_CNT, 2, 1);
      push(F_ERR, 0, 2);
      push(F_TOG, 0, 2);
      sub_k();
      key_valid = 1'b1;
      key_data  = "Z";
      key_del   = 1'b1;
      push(F_WORD, 40'h41, 1);
      push(F_CNT, 1, 1);
      push(F_ERR, 0, 1);
      tick();
      key_del    = 1'b0;
      key_submit = 1'b1;
      push(F_CNT, 1, 1);
      push(F_ERR, 1, 1);
      tick();
      key_submit = 1'b0;
      key_valid  = 1'b0;
      press("b");
      press("c");
      press("d");
      push(F_WORD, 40'h4142434445, 1);
      push(F_CNT, 5, 1);
      press("e");

      // confirm waits for game_rdy
      game_rdy = 1'b0;
      push(F_TOG, 0, 1);
      sub_k();
      push(F_ERR, 0, 1);
      push(F_LCK, 0, 1);
      press("Q");
      tick();
      game_rdy = 1'b1;
      push(F_TOG, 1, 1);
      push(F_LCK, 1, 1);
      push(F_TOG, 0, 2);
      tick();
      tick();

      // single guess with delayed red_busy and game_rdy
      push(F_STG, 1, 1);
      push(F_GUESS, 0, 1);
      press("l");
      push(F_GUESS, 0, 1);
      push(F_BSY, 1, 1);
      push(F_STG, 0, 1);
      sub_k();
      game_rdy = 1'b0;
      hold_4c();
      for (int i = 0; i < 3; i++) hold_4c();
      red_busy = 1'b1;
      hold_4c();
      red_busy = 1'b0;
      for (int i = 0; i < 5; i++) hold_4c();
      game_rdy = 1'b1;
      push(F_GUESS, 40'h4C, 1);
      push(F_BSY, 0, 1);
      tick();

      // repeated letter dips through zero
      send_guess("L", 8'h4C);
      send_guess("L", 8'h4C);

      // timeout without red_busy
      push(F_STG, 1, 1);
      press("l");
      push(F_GUESS, 0, 1);
      push(F_GUESS, 40'h4C, 2);
      push(F_ERR, 0, 65);
      push(F_BSY, 1, 65);
      push(F_ERR, 1, 66);
      push(F_BSY, 0, 66);
      push(F_GUESS, 40'h4C, 66);
      push(F_ERR, 0, 67);
      sub_k();
      repeat (67) tick();

      // rejected submits in guess phase
      push(F_ERR, 1, 1);
      sub_k();
      push(F_STG, 1, 1);
      press("a");
      game_rdy = 1'b0;
      push(F_ERR, 1, 1);
      push(F_STG, 1, 1);
      push(F_BSY, 0, 1);
      sub_k();
      push(F_ERR, 1, 1);
      press("5");
      game_rdy = 1'b1;

      // gameEnd during G_WAIT overrides strobes
      press("l");
      sub_k();
      game_rdy = 1'b0;
      tick();
      red_busy = 1'b1;
      tick();
      red_busy = 1'b0;
      push(F_BSY, 1, 0);
      gameEnd   = 1'b1;
      key_valid = 1'b1;
      key_data  = "1";
      key_del   = 1'b1;
      all_zero(1);
      tick();
      gameEnd   = 1'b0;
      key_valid = 1'b0;
      key_del   = 1'b0;
      game_rdy  = 1'b1;
      push(F_ERR, 1, 1);
      push(F_CNT, 0, 1);
      press("1");

      // filter boundaries
      push(F_WORD, 40'h51, 1);
      press("Q");
      push(F_ERR, 1, 1);
      press("[");
      push(F_ERR, 1, 1);
      press(8'h60);
      push(F_ERR, 1, 1);
      press("@");
      push(F_WORD, 40'h515A, 1);
      push(F_CNT, 2, 1);
      push(F_ERR, 0, 1);
      press("z");

      tick();
      tick();
      chk("sb_left", 40'(sb.size()), 40'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
